// File: rtl/update_buckets.sv
// update_buckets: one ranking pass of a prefix-doubling suffix sort.
// Walks keys already sorted by (primary, secondary), gives each suffix a dense
// rank, scatters the ranks by suffix index, and reports whether every rank is
// distinct (sort converged) and whether any out-of-range index was seen.
module update_buckets #(
    parameter int STRING_LEN = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [STRING_LEN-1:0][2:0][7:0]   keys_in,
    output logic [STRING_LEN-1:0][7:0]        buckets_out,
    output logic                              busy,
    output logic                              done,
    output logic                              all_distinct,
    output logic                              err
);

    localparam int         IW   = (STRING_LEN > 1) ? $clog2(STRING_LEN) : 1;
    localparam logic [7:0] LEN8 = 8'(STRING_LEN);
    localparam logic [7:0] LAST = 8'(STRING_LEN - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, RANK, DONE} state_t;

    state_t                          state_q, state_d;
    logic [7:0]                      counter_q;
    logic [7:0]                      rank_q;
    logic [STRING_LEN-1:0][2:0][7:0] keys_q;
    logic [STRING_LEN-1:0][7:0]      buckets_q;
    logic                            alld_q;
    logic                            err_q;

    logic [IW-1:0] cur_pos;
    logic [IW-1:0] prev_pos;
    logic [7:0]    cur_idx;
    logic [15:0]   cur_pair;
    logic [15:0]   prev_pair;
    logic [7:0]    rank_new;

    // State register; reset returns to IDLE even mid-pass.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start only matters in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CAPTURE;
            CAPTURE: state_d = RANK;
            RANK:    if (counter_q == LAST) state_d = DONE;
            DONE:    if (start) state_d = CAPTURE;
            default: state_d = IDLE;
        endcase
    end

    // Rank of the key under the counter: bump when its (primary, secondary)
    // pair differs from the previous key's pair.
    always_comb begin
        cur_pos   = counter_q[IW-1:0];
        prev_pos  = IW'(counter_q - 8'd1);
        cur_idx   = keys_q[cur_pos][2];
        cur_pair  = keys_q[cur_pos][1:0];
        prev_pair = keys_q[prev_pos][1:0];
        if (counter_q == 8'd0)          rank_new = 8'd0;
        else if (cur_pair != prev_pair) rank_new = rank_q + 8'd1;
        else                            rank_new = rank_q;
    end

    // Datapath: key capture, rank walk, scatter writes and pass flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter_q <= '0;
            rank_q    <= '0;
            keys_q    <= '0;
            buckets_q <= '0;
            alld_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        alld_q <= 1'b0;
                        err_q  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    keys_q    <= keys_in;
                    counter_q <= '0;
                    rank_q    <= '0;
                end
                RANK: begin
                    rank_q    <= rank_new;
                    counter_q <= counter_q + 8'd1;
                    // Out-of-range indices are dropped but still consume a rank step.
                    if (cur_idx < LEN8) buckets_q[cur_idx[IW-1:0]] <= rank_new;
                    else                err_q <= 1'b1;
                    if (counter_q == LAST) alld_q <= (rank_new == LAST);
                end
                default: ;
            endcase
        end
    end

    assign buckets_out  = buckets_q;
    assign busy         = (state_q == CAPTURE) || (state_q == RANK);
    assign done         = (state_q == DONE);
    assign all_distinct = alld_q;
    assign err          = err_q;

endmodule
